// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the single-port response RAM:
//   - default address/data widths
//   - request decode (read / write / collision / idle)
//   - even-parity helper used when RAM_PARITY_EN is defined
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int RAM_ADDR_W    = 8;
  localparam int RAM_DATA_W    = 8;
  // Widest word the parity helper accepts; callers zero-extend, which
  // leaves even parity unchanged.
  localparam int RAM_PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_COLL  = 2'd3
  } ram_op_e;

  // Classify the sampled request pair. A simultaneous read and write is a
  // collision: the write proceeds and the read is dropped.
  function automatic ram_op_e decode_op(input logic rd, input logic wr);
    ram_op_e op;
    case ({rd, wr})
      2'b10:   op = OP_READ;
      2'b01:   op = OP_WRITE;
      2'b11:   op = OP_COLL;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [RAM_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// ---------------------------------------------------------------------------
// ram_sp_array
// Plain single-port storage array: synchronous write, read port presents the
// word at the current address. No reset -- contents are only made reachable
// by the valid bitmap held in the parent.
// Ports:
//   clk_i    write clock
//   we_i     write enable
//   addr_i   word address (shared by read and write)
//   wdata_i  word to store
//   rdata_o  word stored at addr_i
// ---------------------------------------------------------------------------
module ram_sp_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Store the word on a write edge; the array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_sp_resp.sv
// ---------------------------------------------------------------------------
// ram_sp_resp
// Single-port RAM with a response channel: registered read data with a
// one-cycle rd_valid pulse, never-written detection (rd_err), read/write
// collision flag (coll_err) and a saturating count of distinct written
// addresses (fill_cnt / full).
// Optional build macro: RAM_PARITY_EN -- stores an even-parity bit per word
// and adds output par_err, pulsed with rd_valid on a parity mismatch.
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst_n  asynchronous active-low reset
//   rd_en      read request
//   wr_en      write request (wins over rd_en)
//   addr       word address
//   wr_data    write data
//   data_out   registered read data (holds between reads)
//   rd_valid   pulse: data_out updated this cycle
//   rd_err     pulse with rd_valid: address never written
//   coll_err   pulse: rd_en and wr_en were both high
//   fill_cnt   distinct addresses written since reset (0..DEPTH)
//   full       fill_cnt == DEPTH
//   par_err    (RAM_PARITY_EN only) pulse with rd_valid: parity mismatch
// ---------------------------------------------------------------------------
module ram_sp_resp
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              coll_err,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              full
`ifdef RAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int              WORD_W   = DATA_W + PAR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] FILL_ONE = (ADDR_W + 1)'(1);

  ram_op_e           op_s;
  logic              hit_s;
  logic              we_s;
  logic [WORD_W-1:0] word_wr_s;
  logic [WORD_W-1:0] word_rd_s;
  logic [DATA_W-1:0] rd_data_s;

  logic [DEPTH-1:0]  valid_q,    valid_d;
  logic [ADDR_W:0]   fill_q,     fill_d;
  logic              full_q,     full_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q,   rd_err_d;
  logic              coll_q,     coll_d;
`ifdef RAM_PARITY_EN
  logic              par_err_q,  par_err_d;
  logic              par_bad_s;
`endif

  assign op_s  = decode_op(rd_en, wr_en);
  assign hit_s = valid_q[addr];
  // Every write, including the write half of a collision, reaches the array.
  assign we_s  = wr_en;

`ifdef RAM_PARITY_EN
  assign word_wr_s = {even_parity(RAM_PAR_MAX_W'(wr_data)), wr_data};
  assign rd_data_s = word_rd_s[DATA_W-1:0];
  assign par_bad_s = even_parity(RAM_PAR_MAX_W'(rd_data_s)) != word_rd_s[DATA_W];
`else
  assign word_wr_s = wr_data;
  assign rd_data_s = word_rd_s;
`endif

  ram_sp_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (sys_clk),
    .we_i    (we_s),
    .addr_i  (addr),
    .wdata_i (word_wr_s),
    .rdata_o (word_rd_s)
  );

  // Next-state for bitmap, fill counter, read response and error pulses.
  always_comb begin
    valid_d    = valid_q;
    fill_d     = fill_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    coll_d     = 1'b0;
`ifdef RAM_PARITY_EN
    par_err_d  = 1'b0;
`endif
    case (op_s)
      OP_READ: begin
        rd_valid_d = 1'b1;
        if (hit_s) begin
          data_d = rd_data_s;
`ifdef RAM_PARITY_EN
          par_err_d = par_bad_s;
`endif
        end else begin
          // Never-written words read as zero, whatever the array holds.
          data_d   = {DATA_W{1'b0}};
          rd_err_d = 1'b1;
        end
      end
      OP_WRITE, OP_COLL: begin
        valid_d[addr] = 1'b1;
        coll_d        = (op_s == OP_COLL);
        // Only a first write to an address counts; saturate at DEPTH.
        if (!hit_s && (fill_q != FILL_MAX)) begin
          fill_d = fill_q + FILL_ONE;
        end else begin
          fill_d = fill_q;
        end
      end
      OP_IDLE: begin
        data_d = data_q;
      end
      default: begin
        data_d = data_q;
      end
    endcase
    full_d = (fill_d == FILL_MAX);
  end

  // State and registered outputs; reset clears the bitmap, not the array.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q    <= {DEPTH{1'b0}};
      fill_q     <= {(ADDR_W + 1){1'b0}};
      full_q     <= 1'b0;
      data_q     <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      coll_q     <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      valid_q    <= valid_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      coll_q     <= coll_d;
`ifdef RAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign data_out = data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign coll_err = coll_q;
  assign fill_cnt = fill_q;
  assign full     = full_q;
`ifdef RAM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_ram_sp_resp.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_resp
// Self-checking bench for ram_sp_resp. A reference model (associative view of
// memory contents plus a written-address set) predicts every response.
// ---------------------------------------------------------------------------
module tb_ram_sp_resp;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       rd_err;
  logic       coll_err;
  logic [8:0] fill_cnt;
  logic       full;
`ifdef RAM_PARITY_EN
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] m_mem [256];
  bit         m_valid [256];
  logic [7:0] e_data;
  bit         e_rv, e_re, e_ce;
  int         e_fill;

  ram_sp_resp dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .coll_err  (coll_err),
    .fill_cnt  (fill_cnt),
    .full      (full)
`ifdef RAM_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int count_valid();
    int n = 0;
    for (int i = 0; i < 256; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    e_data = 8'h00; e_rv = 1'b0; e_re = 1'b0; e_ce = 1'b0; e_fill = 0;
  endtask

  // Drive one request across one rising edge and advance the model.
  task automatic do_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d;
    @(posedge sys_clk); #1;
    e_rv = 1'b0; e_re = 1'b0; e_ce = 1'b0;
    if (wr) begin
      m_mem[a] = d; m_valid[a] = 1'b1; e_ce = rd;
    end else if (rd) begin
      e_rv = 1'b1;
      e_re = !m_valid[a];
      e_data = m_valid[a] ? m_mem[a] : 8'h00;
    end
    e_fill = count_valid();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic hold_reset();
    sys_rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    if ({data_out, rd_valid, rd_err, coll_err, fill_cnt, full} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h rv=%b re=%b ce=%b fill=%0d full=%b, want all zero",
               data_out, rd_valid, rd_err, coll_err, fill_cnt, full);
    end
    checks++;
    release_reset();
  endtask

  task automatic test_unwritten_read();
    do_op(1'b1, 1'b0, 8'h05, 8'h00);
    if ({rd_valid, rd_err, data_out, fill_cnt} !== {1'b1, 1'b1, 8'h00, 9'd0}) begin
      errors++;
      $display("FAIL unwritten_read: got rv=%b re=%b data=%h fill=%0d, want rv=1 re=1 data=00 fill=0",
               rd_valid, rd_err, data_out, fill_cnt);
    end
    checks++;
  endtask

  task automatic test_write_read();
    do_op(1'b0, 1'b1, 8'h10, 8'hA5);
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_valid: got rv=%b, want 0", rd_valid);
    end
    checks++;
    do_op(1'b1, 1'b0, 8'h10, 8'h00);
    if ({data_out, rd_valid, rd_err, fill_cnt} !== {8'hA5, 1'b1, 1'b0, 9'd1}) begin
      errors++;
      $display("FAIL write_read: got data=%h rv=%b re=%b fill=%0d, want A5 1 0 1",
               data_out, rd_valid, rd_err, fill_cnt);
    end
    checks++;
    // Idle cycle: data holds, pulses drop
    do_op(1'b0, 1'b0, 8'h00, 8'h00);
    if ({data_out, rd_valid, rd_err, coll_err} !== {8'hA5, 3'b000}) begin
      errors++;
      $display("FAIL idle_hold: got data=%h rv=%b re=%b ce=%b, want A5 0 0 0",
               data_out, rd_valid, rd_err, coll_err);
    end
    checks++;
  endtask

  task automatic test_rewrite();
    do_op(1'b0, 1'b1, 8'h10, 8'h11);
    do_op(1'b0, 1'b1, 8'h10, 8'h22);
    if (fill_cnt !== 9'd1) begin
      errors++;
      $display("FAIL rewrite_fill: got %0d, want 1", fill_cnt);
    end
    checks++;
    do_op(1'b1, 1'b0, 8'h10, 8'h00);
    if (data_out !== 8'h22) begin
      errors++;
      $display("FAIL rewrite_data: got %h, want 22", data_out);
    end
    checks++;
  endtask

  task automatic test_collision();
    do_op(1'b1, 1'b1, 8'h20, 8'h3C);
    if ({coll_err, rd_valid, data_out, fill_cnt} !== {1'b1, 1'b0, 8'h22, 9'd2}) begin
      errors++;
      $display("FAIL collision: got ce=%b rv=%b data=%h fill=%0d, want 1 0 22 2",
               coll_err, rd_valid, data_out, fill_cnt);
    end
    checks++;
    do_op(1'b1, 1'b0, 8'h20, 8'h00);
    if ({data_out, rd_valid, coll_err} !== {8'h3C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL collision_readback: got data=%h rv=%b ce=%b, want 3C 1 0",
               data_out, rd_valid, coll_err);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 40));
      do_op(1'b1, 1'b0, a, 8'h00);
      if ({data_out, rd_valid, rd_err} !== {e_data, 1'b1, e_re}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: addr=%h got data=%h rv=%b re=%b, want %h 1 %b",
                 i, a, data_out, rd_valid, rd_err, e_data, e_re);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [7:0] a, d;
    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 47));
      d  = 8'($urandom);
      do_op(rd, wr, a, d);
      if ({data_out, rd_valid, rd_err, coll_err, fill_cnt, full} !==
          {e_data, e_rv, e_re, e_ce, 9'(e_fill), (e_fill == 256)}) begin
        errors++;
        $display("FAIL random[%0d]: op rd=%b wr=%b addr=%h got data=%h rv=%b re=%b ce=%b fill=%0d full=%b, want %h %b %b %b %0d %b",
                 i, rd, wr, a, data_out, rd_valid, rd_err, coll_err, fill_cnt, full,
                 e_data, e_rv, e_re, e_ce, e_fill, (e_fill == 256));
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_read();
    do_op(1'b0, 1'b1, 8'h77, 8'h5E);
    rd_en = 1'b1; addr = 8'h77;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    if ({rd_valid, data_out, fill_cnt, full} !== {1'b0, 8'h00, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_read: got rv=%b data=%h fill=%0d full=%b, want 0 00 0 0",
               rd_valid, data_out, fill_cnt, full);
    end
    checks++;
    rd_en = 1'b0;
    model_reset();
    release_reset();
  endtask

  task automatic test_first_after_reset();
    do_op(1'b0, 1'b1, 8'h33, 8'h5A);
    if (fill_cnt !== 9'd1) begin
      errors++;
      $display("FAIL first_edge_write: got fill=%0d, want 1", fill_cnt);
    end
    checks++;
    do_op(1'b1, 1'b0, 8'h77, 8'h00);
    if ({rd_valid, rd_err, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL stale_after_reset: got rv=%b re=%b data=%h, want 1 1 00",
               rd_valid, rd_err, data_out);
    end
    checks++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      do_op(1'b0, 1'b1, 8'(i), 8'(i));
      if (i == 254 && full !== 1'b0) begin
        errors++;
        $display("FAIL full_early: got full=%b at fill=%0d, want 0", full, fill_cnt);
      end
      if (i == 254) checks++;
    end
    if ({fill_cnt, full} !== {9'd256, 1'b1}) begin
      errors++;
      $display("FAIL fill_all: got fill=%0d full=%b, want 256 1", fill_cnt, full);
    end
    checks++;
    do_op(1'b0, 1'b1, 8'h07, 8'h99);
    if ({fill_cnt, full} !== {9'd256, 1'b1}) begin
      errors++;
      $display("FAIL fill_saturate: got fill=%0d full=%b, want 256 1", fill_cnt, full);
    end
    checks++;
    do_op(1'b1, 1'b0, 8'hC3, 8'h00);
    if (data_out !== 8'hC3) begin
      errors++;
      $display("FAIL fill_readback: got %h, want C3", data_out);
    end
    checks++;
    hold_reset();
    if ({fill_cnt, full} !== {9'd0, 1'b0}) begin
      errors++;
      $display("FAIL fill_reset: got fill=%0d full=%b, want 0 0", fill_cnt, full);
    end
    checks++;
    release_reset();
    do_op(1'b1, 1'b0, 8'hFF, 8'h00);
    if ({rd_valid, rd_err, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL read_ff_after_reset: got rv=%b re=%b data=%h, want 1 1 00",
               rd_valid, rd_err, data_out);
    end
    checks++;
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    do_op(1'b0, 1'b1, 8'h40, 8'h0F);
    do_op(1'b1, 1'b0, 8'h40, 8'h00);
    if ({par_err, rd_valid} !== 2'b01) begin
      errors++;
      $display("FAIL parity_clean: got pe=%b rv=%b, want 0 1", par_err, rd_valid);
    end
    checks++;
    dut.u_array.mem_q[8'h40][0] = ~dut.u_array.mem_q[8'h40][0];
    do_op(1'b1, 1'b0, 8'h40, 8'h00);
    if ({par_err, rd_valid} !== 2'b11) begin
      errors++;
      $display("FAIL parity_flip: got pe=%b rv=%b, want 1 1", par_err, rd_valid);
    end
    checks++;
    do_op(1'b0, 1'b1, 8'h40, 8'h0F);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_unwritten_read();
    test_write_read();
    test_rewrite();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_first_after_reset();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    test_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
